// File: rtl/reg_file_mp_pkg.sv
// Shared defaults and reset-value helper for the multi-port register file.
package rf_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 4;

  // Reset contents: register index (later truncated to DATA_W) or zero.
  function automatic logic [63:0] rf_rst_val(input int idx, input bit rst_idx);
    return rst_idx ? 64'(idx) : 64'd0;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle between decode/writeback (master) and the register file (slave).
interface reg_file_mp_if #(
  parameter int DATA_W = rf_pkg::RF_DATA_W,
  parameter int ADDR_W = rf_pkg::RF_ADDR_W
);

  logic [ADDR_W-1:0] rfi_raddr1;
  logic [ADDR_W-1:0] rfi_raddr2;
  logic [DATA_W-1:0] rfo_rdata1;
  logic [DATA_W-1:0] rfo_rdata2;
  logic              rfo_busy1;
  logic              rfo_busy2;
  logic              rfi_we_a;
  logic [ADDR_W-1:0] rfi_waddr_a;
  logic [DATA_W-1:0] rfi_wdata_a;
  logic              rfi_we_b;
  logic [ADDR_W-1:0] rfi_waddr_b;
  logic [DATA_W-1:0] rfi_wdata_b;
  logic              rfi_rsv_en;
  logic [ADDR_W-1:0] rfi_rsv_addr;
  logic              rfi_flush;
  logic [ADDR_W-1:0] rfi_debug_addr;
  logic [DATA_W-1:0] rfo_debug_data;

  modport master (
    output rfi_raddr1, rfi_raddr2,
    output rfi_we_a, rfi_waddr_a, rfi_wdata_a,
    output rfi_we_b, rfi_waddr_b, rfi_wdata_b,
    output rfi_rsv_en, rfi_rsv_addr, rfi_flush, rfi_debug_addr,
    input  rfo_rdata1, rfo_rdata2, rfo_busy1, rfo_busy2, rfo_debug_data
  );

  modport slave (
    input  rfi_raddr1, rfi_raddr2,
    input  rfi_we_a, rfi_waddr_a, rfi_wdata_a,
    input  rfi_we_b, rfi_waddr_b, rfi_wdata_b,
    input  rfi_rsv_en, rfi_rsv_addr, rfi_flush, rfi_debug_addr,
    output rfo_rdata1, rfo_rdata2, rfo_busy1, rfo_busy2, rfo_debug_data
  );

endinterface

// File: rtl/reg_file_mp_read_port.sv
// One combinational read port: zero-register masking, write bypass, busy masking.
module rf_read_port #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              reg_busy,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] waddr_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] waddr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  logic hit_a;
  logic hit_b;

  assign hit_a = (BYPASS != 0) && we_a && (waddr_a == raddr);
  assign hit_b = (BYPASS != 0) && we_b && (waddr_b == raddr);

  // A bypassed producer means the data is already valid, so busy is masked.
  always_comb begin
    rdata = reg_data;
    busy  = reg_busy;
    if ((ZERO_R0 != 0) && (raddr == '0)) begin
      rdata = '0;
      busy  = 1'b0;
    end else if (hit_b) begin
      rdata = wdata_b;
      busy  = 1'b0;
    end else if (hit_a) begin
      rdata = wdata_a;
      busy  = 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Two-read/two-write register file with bypass, optional zero register and
// a per-register pending-write scoreboard for decode hazard stalls.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W  = RF_DATA_W,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0,
  parameter int RST_IDX = 1
) (
  input logic          rfi_clk,
  input logic          rfi_rst,
  reg_file_mp_if.slave rf
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  logic we_a_eff;
  logic we_b_eff;
  logic rsv_eff;
  logic we_a_rd;
  logic we_b_rd;

  assign we_a_eff = rf.rfi_we_a   && !((ZERO_R0 != 0) && (rf.rfi_waddr_a  == '0));
  assign we_b_eff = rf.rfi_we_b   && !((ZERO_R0 != 0) && (rf.rfi_waddr_b  == '0));
  assign rsv_eff  = rf.rfi_rsv_en && !((ZERO_R0 != 0) && (rf.rfi_rsv_addr == '0));

  // While reset is held the read ports must show reset contents, not bypass data.
  assign we_a_rd = rf.rfi_we_a && rfi_rst;
  assign we_b_rd = rf.rfi_we_b && rfi_rst;

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (we_a_eff) regs_d[rf.rfi_waddr_a] = rf.rfi_wdata_a;
    if (we_b_eff) regs_d[rf.rfi_waddr_b] = rf.rfi_wdata_b;
    if (rf.rfi_flush) begin
      busy_d = '0;
    end else begin
      if (we_a_eff) busy_d[rf.rfi_waddr_a] = 1'b0;
      if (we_b_eff) busy_d[rf.rfi_waddr_b] = 1'b0;
      // A new reservation names a fresh producer, so it beats a retiring write.
      if (rsv_eff)  busy_d[rf.rfi_rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge rfi_clk or negedge rfi_rst) begin
    if (!rfi_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= DATA_W'(rf_rst_val(i, RST_IDX != 0));
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  rf_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .ZERO_R0(ZERO_R0)
  ) u_rd1 (
    .raddr    (rf.rfi_raddr1),
    .reg_data (regs_q[rf.rfi_raddr1]),
    .reg_busy (busy_q[rf.rfi_raddr1]),
    .we_a     (we_a_rd),
    .waddr_a  (rf.rfi_waddr_a),
    .wdata_a  (rf.rfi_wdata_a),
    .we_b     (we_b_rd),
    .waddr_b  (rf.rfi_waddr_b),
    .wdata_b  (rf.rfi_wdata_b),
    .rdata    (rf.rfo_rdata1),
    .busy     (rf.rfo_busy1)
  );

  rf_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .ZERO_R0(ZERO_R0)
  ) u_rd2 (
    .raddr    (rf.rfi_raddr2),
    .reg_data (regs_q[rf.rfi_raddr2]),
    .reg_busy (busy_q[rf.rfi_raddr2]),
    .we_a     (we_a_rd),
    .waddr_a  (rf.rfi_waddr_a),
    .wdata_a  (rf.rfi_wdata_a),
    .we_b     (we_b_rd),
    .waddr_b  (rf.rfi_waddr_b),
    .wdata_b  (rf.rfi_wdata_b),
    .rdata    (rf.rfo_rdata2),
    .busy     (rf.rfo_busy2)
  );

  assign rf.rfo_debug_data = ((ZERO_R0 != 0) && (rf.rfi_debug_addr == '0)) ?
                             '0 : regs_q[rf.rfi_debug_addr];

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench: three 16x16 variants (default, no bypass, zero reg) share
// stimulus; a 32-bit/32-entry variant is driven separately.
module tb_reg_file_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  raddr1, raddr2, waddr_a, waddr_b, rsv_addr, dbg_addr;
  logic [15:0] wdata_a, wdata_b;
  logic        we_a, we_b, rsv_en, flush;

  logic [15:0] rd1 [3];
  logic [15:0] rd2 [3];
  logic [15:0] dbg [3];
  logic        b1  [3];
  logic        b2  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    reg_file_mp_if #(.DATA_W(16), .ADDR_W(4)) rif ();
    assign rif.rfi_raddr1     = raddr1;
    assign rif.rfi_raddr2     = raddr2;
    assign rif.rfi_we_a       = we_a;
    assign rif.rfi_waddr_a    = waddr_a;
    assign rif.rfi_wdata_a    = wdata_a;
    assign rif.rfi_we_b       = we_b;
    assign rif.rfi_waddr_b    = waddr_b;
    assign rif.rfi_wdata_b    = wdata_b;
    assign rif.rfi_rsv_en     = rsv_en;
    assign rif.rfi_rsv_addr   = rsv_addr;
    assign rif.rfi_flush      = flush;
    assign rif.rfi_debug_addr = dbg_addr;
    assign rd1[g] = rif.rfo_rdata1;
    assign rd2[g] = rif.rfo_rdata2;
    assign dbg[g] = rif.rfo_debug_data;
    assign b1[g]  = rif.rfo_busy1;
    assign b2[g]  = rif.rfo_busy2;
    reg_file_mp #(
      .DATA_W(16), .ADDR_W(4),
      .BYPASS((g == 1) ? 0 : 1), .ZERO_R0((g == 2) ? 1 : 0), .RST_IDX(1)
    ) u_dut (
      .rfi_clk (clk),
      .rfi_rst (rst_n),
      .rf      (rif)
    );
  end

  reg_file_mp_if #(.DATA_W(32), .ADDR_W(5)) if_w ();
  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .ZERO_R0(0), .RST_IDX(1)) u_wide (
    .rfi_clk (clk),
    .rfi_rst (rst_n),
    .rf      (if_w)
  );

  localparam int D_RD1 = 0,  D_RD2 = 1,  D_B1 = 2,  D_B2 = 3,  D_DBG = 4;
  localparam int N_RD1 = 5,  N_RD2 = 6,  N_B1 = 7,  N_DBG = 8;
  localparam int Z_RD1 = 9,  Z_RD2 = 10, Z_B1 = 11, Z_DBG = 12;
  localparam int W_RD1 = 13, W_RD2 = 14, W_DBG = 15;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q [$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      D_RD1:   return {16'h0, rd1[0]};
      D_RD2:   return {16'h0, rd2[0]};
      D_B1:    return {31'h0, b1[0]};
      D_B2:    return {31'h0, b2[0]};
      D_DBG:   return {16'h0, dbg[0]};
      N_RD1:   return {16'h0, rd1[1]};
      N_RD2:   return {16'h0, rd2[1]};
      N_B1:    return {31'h0, b1[1]};
      N_DBG:   return {16'h0, dbg[1]};
      Z_RD1:   return {16'h0, rd1[2]};
      Z_RD2:   return {16'h0, rd2[2]};
      Z_B1:    return {31'h0, b1[2]};
      Z_DBG:   return {16'h0, dbg[2]};
      W_RD1:   return if_w.rfo_rdata1;
      W_RD2:   return if_w.rfo_rdata2;
      W_DBG:   return if_w.rfo_debug_data;
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic exp_v(input string name, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  // Monitor: outputs are combinational, so they are presented every cycle and
  // sampled at the falling edge, mid-way between stimulus updates.
  initial begin
    exp_t        e;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = actual(e.sel);
        checks++;
        if (a !== e.exp) begin
          errors++;
          $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, a, e.exp);
        end
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
    we_a = 1'b0; we_b = 1'b0; rsv_en = 1'b0; flush = 1'b0;
    if_w.rfi_we_a = 1'b0;
  endtask

  initial begin
    raddr1 = '0; raddr2 = '0; waddr_a = '0; waddr_b = '0; rsv_addr = '0; dbg_addr = '0;
    wdata_a = '0; wdata_b = '0; we_a = 0; we_b = 0; rsv_en = 0; flush = 0;
    if_w.rfi_raddr1 = '0; if_w.rfi_raddr2 = '0; if_w.rfi_we_a = 0; if_w.rfi_waddr_a = '0;
    if_w.rfi_wdata_a = '0; if_w.rfi_we_b = 0; if_w.rfi_waddr_b = '0; if_w.rfi_wdata_b = '0;
    if_w.rfi_rsv_en = 0; if_w.rfi_rsv_addr = '0; if_w.rfi_flush = 0; if_w.rfi_debug_addr = '0;
    #12 rst_n = 1'b1;

    next();
    raddr1 = 5; raddr2 = 15; dbg_addr = 7;
    if_w.rfi_raddr1 = 31; if_w.rfi_debug_addr = 20;
    exp_v("rst_rd1", D_RD1, 32'h5);
    exp_v("rst_rd2", D_RD2, 32'hF);
    exp_v("rst_busy1", D_B1, 32'h0);
    exp_v("w_rst_r31", W_RD1, 32'h1F);
    exp_v("w_rst_r20", W_DBG, 32'h14);

    next();
    we_a = 1; waddr_a = 3; wdata_a = 16'h1111;
    we_b = 1; waddr_b = 3; wdata_b = 16'h2222; raddr1 = 3;
    if_w.rfi_we_a = 1; if_w.rfi_waddr_a = 31; if_w.rfi_wdata_a = 32'hDEADBEEF;
    exp_v("coll_byp", D_RD1, 32'h2222);
    exp_v("coll_nobyp_old", N_RD1, 32'h0003);
    exp_v("w_byp", W_RD1, 32'hDEADBEEF);

    next();
    raddr1 = 3;
    if_w.rfi_raddr2 = 31;
    exp_v("coll_stored", D_RD1, 32'h2222);
    exp_v("coll_nobyp_stored", N_RD1, 32'h2222);
    exp_v("w_rd1", W_RD1, 32'hDEADBEEF);
    exp_v("w_rd2", W_RD2, 32'hDEADBEEF);
    exp_v("w_r20", W_DBG, 32'h14);

    next();
    we_a = 1; waddr_a = 7; wdata_a = 16'hBEEF; raddr2 = 7; dbg_addr = 7;
    exp_v("byp_rd2", D_RD2, 32'hBEEF);
    exp_v("byp_busy2", D_B2, 32'h0);
    exp_v("byp_dbg_old", D_DBG, 32'h7);
    exp_v("nobyp_rd2", N_RD2, 32'h7);

    next();
    exp_v("dbg_new", D_DBG, 32'hBEEF);
    exp_v("nobyp_dbg_new", N_DBG, 32'hBEEF);

    next();
    rsv_en = 1; rsv_addr = 9; raddr1 = 9;
    exp_v("rsv_same_cyc", D_B1, 32'h0);

    next();
    exp_v("rsv_busy", D_B1, 32'h1);
    exp_v("rsv_busy_nb", N_B1, 32'h1);
    exp_v("rsv_rd1", D_RD1, 32'h9);

    next();
    we_a = 1; waddr_a = 9; wdata_a = 16'h00AA;
    exp_v("wr9_busy_byp", D_B1, 32'h0);
    exp_v("wr9_rd_byp", D_RD1, 32'h00AA);
    exp_v("wr9_busy_nb", N_B1, 32'h1);
    exp_v("wr9_rd_nb", N_RD1, 32'h9);

    next();
    exp_v("wr9_busy_after", D_B1, 32'h0);
    exp_v("wr9_busy_after_nb", N_B1, 32'h0);
    exp_v("wr9_rd_after_nb", N_RD1, 32'h00AA);

    next();
    we_a = 1; waddr_a = 9; wdata_a = 16'h0055; rsv_en = 1; rsv_addr = 9;
    exp_v("rsvwr_rd_byp", D_RD1, 32'h0055);
    exp_v("rsvwr_busy_byp", D_B1, 32'h0);

    next();
    exp_v("rsvwr_busy", D_B1, 32'h1);
    exp_v("rsvwr_busy_nb", N_B1, 32'h1);
    exp_v("rsvwr_rd", D_RD1, 32'h0055);

    next();
    flush = 1; rsv_en = 1; rsv_addr = 9;
    exp_v("flush_pre", D_B1, 32'h1);

    next();
    exp_v("flush_busy", D_B1, 32'h0);
    exp_v("flush_busy_nb", N_B1, 32'h0);

    next();
    rsv_en = 1; rsv_addr = 9;

    next();
    rsv_en = 1; rsv_addr = 9;
    exp_v("rsv_again_pre", D_B1, 32'h1);

    next();
    we_b = 1; waddr_b = 9; wdata_b = 16'h0077;
    exp_v("rsv_twice_busy", N_B1, 32'h1);
    exp_v("wrb_busy_byp", D_B1, 32'h0);
    exp_v("wrb_rd_byp", D_RD1, 32'h0077);

    next();
    exp_v("wrb_busy", D_B1, 32'h0);
    exp_v("wrb_busy_nb", N_B1, 32'h0);
    exp_v("wrb_rd_nb", N_RD1, 32'h0077);

    next();
    we_a = 1; waddr_a = 0; wdata_a = 16'h1234; rsv_en = 1; rsv_addr = 0;
    raddr1 = 0; raddr2 = 1; dbg_addr = 0;
    exp_v("z_rd0", Z_RD1, 32'h0);
    exp_v("z_busy0", Z_B1, 32'h0);
    exp_v("z_rd1_reset", Z_RD2, 32'h1);
    exp_v("d_r0_byp", D_RD1, 32'h1234);

    next();
    exp_v("z_rd0_after", Z_RD1, 32'h0);
    exp_v("z_busy0_after", Z_B1, 32'h0);
    exp_v("z_dbg0", Z_DBG, 32'h0);
    exp_v("z_r1", Z_RD2, 32'h1);
    exp_v("d_r0_stored", D_DBG, 32'h1234);
    exp_v("d_r0_busy", D_B1, 32'h1);

    next();
    rsv_en = 1; rsv_addr = 9; raddr1 = 3; raddr2 = 9;

    next();
    exp_v("pre_rst_rd1", D_RD1, 32'h2222);
    exp_v("pre_rst_busy2", D_B2, 32'h1);

    next();
    rst_n = 1'b0;
    exp_v("arst_rd1", D_RD1, 32'h3);
    exp_v("arst_rd2", D_RD2, 32'h9);
    exp_v("arst_busy2", D_B2, 32'h0);
    exp_v("arst_rd1_nb", N_RD1, 32'h3);
    exp_v("arst_w_r31", W_RD1, 32'h1F);

    next();
    raddr1 = 5; raddr2 = 15; we_a = 1; waddr_a = 5; wdata_a = 16'hAAAA;
    exp_v("inrst_rd1", D_RD1, 32'h5);
    exp_v("inrst_rd2", D_RD2, 32'hF);
    exp_v("inrst_busy1", D_B1, 32'h0);
    exp_v("inrst_busy2", D_B2, 32'h0);

    next();
    rst_n = 1'b1;
    exp_v("postrst_rd1", D_RD1, 32'h5);
    exp_v("postrst_busy2", D_B2, 32'h0);

    next();
    next();
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
